// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM state enum and the double-dabble adjust constants.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_converter_digit_adjust.sv
// bcd_digit_adjust: one double-dabble digit correction, +3 when >= 5.
// Ports: digit_i (4b BCD field in), digit_o (4b adjusted field out).
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // 4-bit wrap is intended: inputs never exceed 9 in a legal run
  assign digit_o = (digit_i >= BCD_ADJ_THRESH)
                 ? digit_i + BCD_ADJ_ADD
                 : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to packed BCD, one iteration/cycle.
// Ports: clock100Mhz, reset (async low), bin_in/in_valid/in_ready,
// bcd_out, out_valid; digit_blank only with BIN2BCD_BLANK_EN defined.
module bin_to_bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock100Mhz,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     digit_blank
`endif
);

  localparam int SR_W  = 4 * DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [SR_W-1:0]     sr_adj, sr_shl;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                out_valid_q, out_valid_d;
  logic                accept;
  logic                last;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // BCD fields sit above the binary part and are adjusted in parallel
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sr_q[WIDTH+4*g +: 4]),
      .digit_o (sr_adj[WIDTH+4*g +: 4])
    );
  end

  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];
  assign sr_shl            = sr_adj << 1;

  always_ff @(posedge clock100Mhz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = 1'b0;
    if (accept) begin
      sr_d  = {{(4*DIGITS){1'b0}}, bin_in};
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      sr_d  = sr_shl;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        bcd_d       = sr_shl[SR_W-1 -: 4*DIGITS];
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock100Mhz or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_out   = bcd_q;
  assign out_valid = out_valid_q;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
  logic              zero_run;

  // Walk from the top digit down; units digit is never blanked
  always_comb begin
    zero_run = 1'b1;
    blank_nx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (bcd_d[4*i +: 4] == 4'd0);
      blank_nx[i] = zero_run;
    end
    blank_nx[0] = 1'b0;
  end

  always_comb begin
    blank_d = blank_q;
    if (last) blank_d = blank_nx;
  end

  always_ff @(posedge clock100Mhz or negedge reset) begin
    if (!reset) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign digit_blank = blank_q;
`endif

endmodule
